// File: rtl/iterative_booth_mul.sv
// Radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One Booth digit per cycle, 17 digits. Defining MUL_EARLY_EXIT_EN enables early exit.
module iterative_booth_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush_ex,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        done
);

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg;
    logic [65:0] acc_reg;
    logic [65:0] mcand_reg;
    logic [33:0] mplr_reg;
    logic        booth_reg;
    logic [4:0]  iter_reg;
    logic [31:0] y_reg;
    logic        done_reg;
    logic        hi_reg;

    logic        a_signed;
    logic        b_signed;
    logic [33:0] a_ext;
    logic [33:0] b_ext;
    logic [65:0] mcand_init;
    logic [65:0] addend;
    logic [65:0] acc_next;
    logic [33:0] mplr_next;
    logic        booth_next;
    logic        rest_zero;
    logic        last_digit;
    logic        abort;
    logic        unused_funct3;

    assign unused_funct3 = funct3[2];
    assign abort = !valid || flush_ex;

    always_comb begin
        a_signed   = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
        b_signed   = (funct3[1:0] == 2'b01);
        a_ext      = {{2{a_signed & a[31]}}, a};
        b_ext      = {{2{b_signed & b[31]}}, b};
        mcand_init = {{32{a_ext[33]}}, a_ext};
    end

    // Booth digit from {mplr[1:0], booth bit}: 0, +-M, +-2M.
    always_comb begin
        addend = '0;
        case ({mplr_reg[1:0], booth_reg})
            3'b001, 3'b010: addend = mcand_reg;
            3'b011:         addend = mcand_reg << 1;
            3'b100:         addend = ~(mcand_reg << 1) + 66'd1;
            3'b101, 3'b110: addend = ~mcand_reg + 66'd1;
            default:        addend = '0;
        endcase
    end

    always_comb begin
        acc_next   = acc_reg + addend;
        mplr_next  = {{2{mplr_reg[33]}}, mplr_reg[33:2]};
        booth_next = mplr_reg[1];
        // Remaining multiplier bits all equal means every later digit is zero.
        rest_zero  = (&{mplr_next, booth_next}) || !(|{mplr_next, booth_next});
        last_digit = (iter_reg == 5'd16) || (EARLY_EXIT && rest_zero);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            mcand_reg <= '0;
            mplr_reg  <= '0;
            booth_reg <= 1'b0;
            iter_reg  <= '0;
            y_reg     <= '0;
            done_reg  <= 1'b0;
            hi_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid && !flush_ex) begin
                        hi_reg    <= (funct3[1:0] != 2'b00);
                        acc_reg   <= '0;
                        iter_reg  <= '0;
                        booth_reg <= 1'b0;
                        if (a == 32'd0 || b == 32'd0) begin
                            mcand_reg <= '0;
                            mplr_reg  <= '0;
                            y_reg     <= '0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            mcand_reg <= mcand_init;
                            mplr_reg  <= b_ext;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        acc_reg   <= '0;
                        mcand_reg <= '0;
                        mplr_reg  <= '0;
                        booth_reg <= 1'b0;
                        iter_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg   <= acc_next;
                        mcand_reg <= mcand_reg << 2;
                        mplr_reg  <= mplr_next;
                        booth_reg <= booth_next;
                        iter_reg  <= iter_reg + 5'd1;
                        if (last_digit) begin
                            y_reg     <= hi_reg ? acc_next[63:32] : acc_next[31:0];
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    if (abort) begin
                        acc_reg   <= '0;
                        mcand_reg <= '0;
                        mplr_reg  <= '0;
                        booth_reg <= 1'b0;
                        iter_reg  <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign y = y_reg;
    // An abort during the DONE cycle suppresses the pulse.
    assign done = done_reg && !abort;

endmodule

// File: tb/tb_iterative_booth_mul.sv
// Directed and random checks for iterative_booth_mul; expected results flow through a queue.
// Latency expectations follow MUL_EARLY_EXIT_EN when it is defined.
module tb_iterative_booth_mul;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        flush_ex;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        done;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_y;

    always #5 clk = ~clk;

    iterative_booth_mul dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .flush_ex (flush_ex),
        .funct3   (funct3),
        .a        (a),
        .b        (b),
        .y        (y),
        .done     (done)
    );

    function automatic logic [31:0] model_y(input logic [2:0] f3, input logic [31:0] aa, input logic [31:0] bb);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] prod;
        logic        as;
        logic        bs;
        as = (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
        bs = (f3[1:0] == 2'b01);
        sa = {{32{as & aa[31]}}, aa};
        sb = {{32{bs & bb[31]}}, bb};
        prod = sa * sb;
        return (f3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] aa, input logic [31:0] bb);
        logic [34:0] v;
        logic        bs;
        if (aa == 32'd0 || bb == 32'd0) return 1;
        bs = (f3[1:0] == 2'b01);
        v = {bs & bb[31], bs & bb[31], bb, 1'b0};
`ifdef MUL_EARLY_EXIT_EN
        for (int k = 1; k <= 17; k++) begin
            v = $signed(v) >>> 2;
            if (v == 35'd0 || (&v)) return k + 1;
        end
`endif
        return v[0] ? 18 : 18;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] aa,
                          input logic [31:0] bb, input bit keep_valid);
        int          lat;
        int          el;
        bit          got;
        logic [31:0] popped;
        el = model_lat(f3, aa, bb);
        @(negedge clk);
        funct3 = f3;
        a = aa;
        b = bb;
        valid = 1'b1;
        flush_ex = 1'b0;
        exp_q.push_back(model_y(f3, aa, bb));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            got = done;
        end
        check({tag, "_done"}, {63'd0, got}, 64'd1);
        check({tag, "_lat"}, lat, el);
        popped = exp_q.pop_front();
        check({tag, "_y"}, {32'd0, y}, {32'd0, popped});
        last_y = popped;
        $display("%s: funct3=%0d a=%h b=%h y=%h exp=%h lat=%0d", tag, f3, aa, bb, y, popped, lat);
        if (!keep_valid) valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int fc;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        valid = 1'b0;
        flush_ex = 1'b0;
        funct3 = 3'd0;
        a = '0;
        b = '0;
        last_y = '0;
        repeat (3) @(negedge clk);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_y", {32'd0, y}, 64'd0);
        reset = 1'b0;

        run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 1'b0);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mul_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu_ones", 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu_zero", 3'b011, 32'h1234_5678, 32'd0, 1'b1);
        run_op("mul_b2b", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Flush mid-CALC: no pulse, y holds.
        @(negedge clk);
        funct3 = 3'b000;
        a = 32'd3;
        b = 32'd5;
        valid = 1'b1;
        fc = (model_lat(3'b000, 32'd3, 32'd5) > 5) ? 5 : 1;
        seen = 1'b0;
        for (int c = 1; c <= fc; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        flush_ex = 1'b1;
        @(negedge clk);
        if (done) seen = 1'b1;
        flush_ex = 1'b0;
        valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush_no_done", {63'd0, seen}, 64'd0);
        check("flush_y_hold", {32'd0, y}, {32'd0, last_y});
        $display("flush: a=3 b=5 flushed at cycle %0d done_seen=%0d y=%h", fc, seen, y);
        run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 1'b0);

        // valid rising together with flush_ex is not accepted.
        @(negedge clk);
        funct3 = 3'b000;
        a = 32'd7;
        b = 32'd6;
        valid = 1'b1;
        flush_ex = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        flush_ex = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush_issue_no_done", {63'd0, seen}, 64'd0);
        $display("flush_issue: done_seen=%0d", seen);

        // Reset mid-CALC.
        @(negedge clk);
        funct3 = 3'b011;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        valid = 1'b1;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_y", {32'd0, y}, 64'd0);
        $display("midreset: done=%0d y=%h", done, y);
        reset = 1'b0;
        last_y = '0;
        run_op("mulh_neg", 3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd1 : $urandom;
            if (i == 5) ra = 32'h8000_0000;
            run_op("rand", rf, ra, rb, i[0]);
        end

        check("queue_empty", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/iterative_booth_mul.md
# iterative_booth_mul

- Multi-cycle RV32M multiply unit in the execute stage, beside the non-restoring divider.
- Shares the divider's level-valid / done-pulse handshake and flush behaviour, so the hazard unit stalls both the same way.
- Executes MUL, MULH, MULHSU and MULHU.
- Uses a radix-4 Booth recoder with a fixed accumulator and a left-shifting multiplicand.

## Interface
Parameters:
- none; datapath is fixed at 32-bit operands and a 66-bit internal product.

Ports:
- clk  in  1  — single clock; all state changes on rising edge.
- reset  in  1  — synchronous, active-high; forces IDLE and clears all registers.
- valid  in  1  — level request; held high by upstream from issue until done; low means abort.
- flush_ex  in  1  — synchronous abort of the in-flight operation.
- funct3  in  3  — only [1:0] used: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; [2] ignored.
- a  in  32  — rs1 operand; must be stable while valid is high.
- b  in  32  — rs2 operand; must be stable while valid is high.
- y  out  32  — result register; meaningful only while done=1.
- done  out  1  — one-cycle completion pulse.

## Operation
States:
- IDLE:
  - valid=1 and flush_ex=0 → accept: load registers, go to CALC.
  - If a==0 or b==0 on acceptance → go directly to DONE with y=0.
- CALC, one Booth digit per cycle:
  - Digit d from mplr[1:0] and the Booth bit: +0, ±M, ±2M.
  - acc += d·mcand (66-bit wrap).
  - mcand <<= 2.
  - {mplr, booth bit} arithmetic-shift right by 2.
  - iter counter increments; at iter==16 (17th digit) → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - y ← funct3[1:0]==00 ? acc[31:0] : acc[63:32]; captured on the edge entering DONE.
  - Next state IDLE unconditionally.
- Abort, from CALC or DONE:
  - Condition: valid==0 or flush_ex==1.
  - Synchronous → IDLE; acc, mcand, mplr and the counter cleared.
  - done forced 0 that cycle; y keeps its previous value.

Operand extension to 34 bits:
- a: sign-extended if funct3[1:0] ∈ {01,10}, else zero-extended.
- b: sign-extended if funct3[1:0]==01, else zero-extended.
- mcand = 66-bit sign extension of extended a.
- mplr = extended b; Booth bit initialised to 0.

Arithmetic and width rules:
- 17 digits cover the 34-bit multiplier; the 66-bit acc holds the exact signed product.
- All arithmetic is modulo 2^66; no overflow flag.
- MUL result is independent of signedness.

Other rules:
- No special case for 0x80000000 × 0xFFFFFFFF; Booth handles it exactly.
- Back-to-back: if valid stays high after done, the next IDLE cycle accepts a new operation from the current a/b/funct3.

## Timing
- Reset values: done=0, y=32'h0, state IDLE, all datapath registers 0.
- Cycle 0 = acceptance edge (IDLE, valid=1). Done asserted:
  - Zero-operand fast path: cycle 1.
  - Full operation: cycle 18, i.e. 17 CALC cycles + DONE.
  - Early exit (if compiled in): cycle k+1, where k = number of CALC cycles executed.
- Minimum issue-to-issue: 2 cycles (fast path); maximum: 19.
- Simultaneous events:
  - reset wins over everything.
  - Abort wins over a DONE transition in the same cycle; done stays 0.
  - valid rising on the same cycle as flush_ex is not accepted.
- y holds its value after done until the next DONE capture.

## Configuration
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - At the end of each CALC cycle, if the post-shift {mplr, booth bit} bits are all 0 or all 1, every remaining digit is zero.
  - In that case the FSM goes to DONE next; acc is already final, so no realignment is needed.
  - Latency is 2..18 cycles.
- Undefined:
  - Always 17 CALC cycles; done at cycle 18 except on the zero fast path.
- Results are identical either way.

## Test plan
- MUL a=7 b=6 → y=0x0000002A; done at cycle 18 (no macro), cycle 3 with MUL_EARLY_EXIT_EN.
- MULH a=b=0x80000000 → y=0x40000000; MUL with the same operands → y=0x00000000.
- MULHSU a=0xFFFFFFFF b=0xFFFFFFFF → y=0xFFFFFFFF; MULHU same operands → y=0xFFFFFFFE.
- MULHU a=0x12345678 b=0 → done at cycle 1, y=0; then valid held high, MUL a=b=0xFFFFFFFF → y=0x00000001.
- MUL a=3 b=5, flush_ex pulsed at cycle 5 → no done pulse, y unchanged. Re-issue the same op → y=0x0000000F with nominal latency.
- reset asserted mid-CALC (cycle 9) → next cycle done=0, y=0, IDLE; a subsequent MULH a=0xFFFFFFFE b=3 → y=0xFFFFFFFF.
